// File: rtl/key_cmd_pkg.sv
// rtl/key_cmd_pkg.sv - shared states, key pattern encodings and default timing for the key command encoder
package key_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_FIRE,
    ST_HOLD,
    ST_REPEAT
  } state_e;

  // Pattern bit order is {key_jump, key_left, key_right}
  localparam logic [2:0] PAT_NONE  = 3'b000;
  localparam logic [2:0] PAT_RIGHT = 3'b001;
  localparam logic [2:0] PAT_LEFT  = 3'b010;
  localparam logic [2:0] PAT_JUMP  = 3'b100;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_RATE     = 4;

  function automatic logic pat_is_key(input logic [2:0] p);
    return (p == PAT_RIGHT) || (p == PAT_LEFT) || (p == PAT_JUMP);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - pattern register and stability counter; flags the sample that completes a stable run
module key_debounce
  import key_cmd_pkg::*;
#(
  parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] pat_in,
  output logic       changed,
  output logic       accepted
);

  localparam logic [7:0] LIMIT = 8'(CYCLES);

  logic [2:0] pat_q, pat_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    pat_d   = pat_in;
    changed = (pat_in != pat_q);
    cnt_d   = cnt_q;
    if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + 8'd1;
    end
    // Saturating at LIMIT makes acceptance a single-edge event per stable run
    accepted = (cnt_d == LIMIT) && (changed || (cnt_q != LIMIT));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pat_q <= PAT_NONE;
      cnt_q <= 8'd0;
    end else begin
      pat_q <= pat_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_cmd_encoder.sv
// rtl/key_cmd_encoder.sv - turns debounced cursor keys into advance/retreat/load pulses with auto-repeat
module key_cmd_encoder
  import key_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       key_right,
  input  logic       key_left,
  input  logic       key_jump,
  input  logic [3:0] jump_val,
  output logic       increase,
  output logic       decrease,
  output logic       parallel,
  output logic [3:0] load
);

  localparam logic [7:0] DELAY_LIM = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_LIM  = 8'(REPEAT_RATE);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       increase_q, increase_d;
  logic       decrease_q, decrease_d;
  logic       parallel_q, parallel_d;
  logic [3:0] load_q, load_d;

  logic [2:0] pat;
  logic       is_key;
  logic       changed;
  logic       accepted;
  logic       fire;
  logic       repeat_pulse;
  logic [7:0] limit;

  assign pat    = {key_jump, key_left, key_right};
  assign is_key = pat_is_key(pat);

  key_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (CLK),
    .clr     (CLR),
    .pat_in  (pat),
    .changed (changed),
    .accepted(accepted)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    load_d       = load_q;
    fire         = 1'b0;
    repeat_pulse = 1'b0;
    limit        = (state_q == ST_REPEAT) ? RATE_LIM : DELAY_LIM;

    case (state_q)
      ST_IDLE, ST_DEBOUNCE: begin
        if (!is_key) begin
          state_d = ST_IDLE;
        end else if (accepted) begin
          fire = 1'b1;
        end else begin
          state_d = ST_DEBOUNCE;
        end
      end
      ST_FIRE, ST_HOLD, ST_REPEAT: begin
        if (changed) begin
          if (!is_key) begin
            state_d = ST_IDLE;
          end else if (accepted) begin
            fire = 1'b1;
          end else begin
            state_d = ST_DEBOUNCE;
          end
        end else if (pat == PAT_JUMP) begin
          // Jump never auto-repeats; timer is frozen so it cannot run away
          state_d = ST_HOLD;
        end else if (timer_q == limit) begin
          repeat_pulse = 1'b1;
          state_d      = ST_REPEAT;
          timer_d      = 8'd1;
        end else begin
          timer_d = timer_q + 8'd1;
          if (state_q == ST_FIRE) begin
            state_d = ST_HOLD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fire) begin
      state_d = ST_FIRE;
      timer_d = 8'd1;
    end

    increase_d = (fire || repeat_pulse) && (pat == PAT_RIGHT);
    decrease_d = (fire || repeat_pulse) && (pat == PAT_LEFT);
    parallel_d = fire && (pat == PAT_JUMP);
    if (parallel_d) begin
      load_d = jump_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      timer_q    <= 8'd0;
      increase_q <= 1'b0;
      decrease_q <= 1'b0;
      parallel_q <= 1'b0;
      load_q     <= 4'b0000;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      increase_q <= increase_d;
      decrease_q <= decrease_d;
      parallel_q <= parallel_d;
      load_q     <= load_d;
    end
  end

  assign increase = increase_q;
  assign decrease = decrease_q;
  assign parallel = parallel_q;
  assign load     = load_q;

endmodule

// File: tb/tb_key_cmd_encoder.sv
// tb/tb_key_cmd_encoder.sv - self-checking bench: vector table, directed scenarios, randomized run against a run-length model
module tb_key_cmd_encoder;
  import key_cmd_pkg::*;

  localparam int D     = DEF_DEBOUNCE_CYCLES;
  localparam int DELAY = DEF_REPEAT_DELAY;
  localparam int RATE  = DEF_REPEAT_RATE;

  logic       CLK;
  logic       CLR;
  logic       key_right, key_left, key_jump;
  logic [3:0] jump_val;
  logic       increase, decrease, parallel;
  logic [3:0] load;

  key_cmd_encoder dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .key_right(key_right),
    .key_left (key_left),
    .key_jump (key_jump),
    .jump_val (jump_val),
    .increase (increase),
    .decrease (decrease),
    .parallel (parallel),
    .load     (load)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pulse depends only on how long the current valid pattern has been held.
  logic [2:0] m_prev;
  int         m_run;
  logic [3:0] m_load;
  logic       m_inc, m_dec, m_par;

  task automatic model_step(input logic clr, input logic [2:0] pat, input logic [3:0] jv);
    logic valid, first, rep;
    m_inc = 1'b0; m_dec = 1'b0; m_par = 1'b0;
    if (clr) begin
      m_prev = 3'b000; m_run = 0; m_load = 4'h0;
    end else begin
      if (pat == m_prev) m_run++;
      else begin m_prev = pat; m_run = 1; end
      valid = (pat == 3'b001) || (pat == 3'b010) || (pat == 3'b100);
      first = valid && (m_run == D);
      rep   = valid && (pat != 3'b100) && (m_run >= D + DELAY) && (((m_run - D - DELAY) % RATE) == 0);
      m_inc = (first || rep) && (pat == 3'b001);
      m_dec = (first || rep) && (pat == 3'b010);
      m_par = first && (pat == 3'b100);
      if (m_par) m_load = jv;
    end
  endtask

  task automatic tick(input logic clr, input logic [2:0] pat, input logic [3:0] jv);
    CLR = clr;
    {key_jump, key_left, key_right} = pat;
    jump_val = jv;
    @(posedge CLK);
    model_step(clr, pat, jv);
    @(negedge CLK);
    check("model_increase", 32'(increase), 32'(m_inc));
    check("model_decrease", 32'(decrease), 32'(m_dec));
    check("model_parallel", 32'(parallel), 32'(m_par));
    check("model_load",     32'(load),     32'(m_load));
  endtask

  // Per-cycle invariants: one-hot-or-none pulses, load only moves with parallel or reset
  logic       started = 1'b0;
  logic       clr_seen = 1'b1;
  logic [3:0] prev_load = 4'h0;
  always @(posedge CLK) clr_seen <= CLR;
  always @(negedge CLK) begin
    if (started) begin
      check("onehot0_pulses", 32'($onehot0({increase, decrease, parallel})), 32'd1);
      if (!clr_seen && (load !== prev_load)) check("load_only_with_parallel", 32'(parallel), 32'd1);
    end
    prev_load <= load;
  end

  typedef struct {
    logic       clr;
    logic [2:0] pat;
    logic [3:0] jv;
    logic       e_inc, e_dec, e_par;
    logic [3:0] e_load;
  } vec_t;

  vec_t vecs[16];
  int   exp_rep[7];
  int   inc_cycles[$];
  int   cnt_a, cnt_b, cnt_c;

  initial begin
    vecs[0]  = '{1'b1, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 3'b100, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[2]  = '{1'b0, 3'b100, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 3'b100, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[4]  = '{1'b0, 3'b100, 4'h7, 1'b0, 1'b0, 1'b1, 4'h7};
    vecs[5]  = '{1'b0, 3'b100, 4'h9, 1'b0, 1'b0, 1'b0, 4'h7};
    vecs[6]  = '{1'b0, 3'b000, 4'h9, 1'b0, 1'b0, 1'b0, 4'h7};
    vecs[7]  = '{1'b0, 3'b010, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7};
    vecs[8]  = '{1'b0, 3'b010, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7};
    vecs[9]  = '{1'b0, 3'b010, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7};
    vecs[10] = '{1'b0, 3'b010, 4'h0, 1'b0, 1'b1, 1'b0, 4'h7};
    vecs[11] = '{1'b1, 3'b010, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[12] = '{1'b0, 3'b010, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[13] = '{1'b0, 3'b010, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[14] = '{1'b0, 3'b010, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[15] = '{1'b0, 3'b010, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    exp_rep = '{4, 20, 24, 28, 32, 36, 40};

    CLR = 1'b1; key_right = 1'b0; key_left = 1'b0; key_jump = 1'b0; jump_val = 4'h0;
    m_prev = 3'b000; m_run = 0; m_load = 4'h0;
    @(negedge CLK);
    tick(1'b1, 3'b000, 4'h0);
    started = 1'b1;

    foreach (vecs[i]) begin
      tick(vecs[i].clr, vecs[i].pat, vecs[i].jv);
      check($sformatf("vec%0d_increase", i), 32'(increase), 32'(vecs[i].e_inc));
      check($sformatf("vec%0d_decrease", i), 32'(decrease), 32'(vecs[i].e_dec));
      check($sformatf("vec%0d_parallel", i), 32'(parallel), 32'(vecs[i].e_par));
      check($sformatf("vec%0d_load", i),     32'(load),     32'(vecs[i].e_load));
    end

    // right held 40 cycles: first pulse, delayed repeat, then steady rate
    tick(1'b1, 3'b000, 4'h0);
    tick(1'b0, 3'b000, 4'h0);
    cnt_a = 0;
    for (int c = 1; c <= 40; c++) begin
      tick(1'b0, PAT_RIGHT, 4'h0);
      if (increase) inc_cycles.push_back(c);
      if (decrease || parallel) cnt_a++;
    end
    tick(1'b0, 3'b000, 4'h0);
    check("right_hold_pulse_count", 32'(inc_cycles.size()), 32'd7);
    check("right_hold_other_outputs", 32'(cnt_a), 32'd0);
    for (int i = 0; i < 7; i++)
      check($sformatf("right_hold_pulse%0d_cycle", i),
            (i < inc_cycles.size()) ? 32'(inc_cycles[i]) : 32'hFFFF_FFFF, 32'(exp_rep[i]));

    // jump held 30 cycles: exactly one load, no repeats
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 30; c++) begin
      tick(1'b0, PAT_JUMP, 4'hA);
      if (parallel) cnt_a++;
      if (increase || decrease) cnt_b++;
    end
    check("jump_parallel_count", 32'(cnt_a), 32'd1);
    check("jump_load_value", 32'(load), 32'hA);
    check("jump_other_outputs", 32'(cnt_b), 32'd0);
    tick(1'b0, 3'b000, 4'h0);

    // bouncing left key never settles
    cnt_a = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, (c == 2 || c >= 5) ? PAT_NONE : PAT_LEFT, 4'h0);
      if (decrease || increase || parallel) cnt_a++;
    end
    check("bounce_no_pulse", 32'(cnt_a), 32'd0);

    // left+right together is invalid
    cnt_a = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, PAT_LEFT | PAT_RIGHT, 4'h3);
      if (decrease || increase || parallel) cnt_a++;
    end
    check("multi_key_no_pulse", 32'(cnt_a), 32'd0);
    tick(1'b0, 3'b000, 4'h0);

    // reset during repeat, key held through release
    for (int c = 1; c <= 26; c++) tick(1'b0, PAT_RIGHT, 4'h0);
    tick(1'b1, PAT_RIGHT, 4'h0);
    check("clr_outputs_zero", 32'({increase, decrease, parallel, load}), 32'd0);
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 4; c++) begin
      tick(1'b0, PAT_RIGHT, 4'h0);
      if (increase && cnt_b == 0) cnt_b = c;
      if (increase) cnt_a++;
    end
    check("clr_redebounce_first_cycle", 32'(cnt_b), 32'd4);
    check("clr_redebounce_count", 32'(cnt_a), 32'd1);

    // randomized segments against the model
    for (int s = 0; s < 150; s++) begin
      logic [2:0] p;
      int         len;
      logic [3:0] jv;
      case ($urandom_range(0, 9))
        0, 1:    p = PAT_RIGHT;
        2, 3:    p = PAT_LEFT;
        4, 5:    p = PAT_JUMP;
        6, 7:    p = PAT_NONE;
        default: p = 3'($urandom_range(3, 7));
      endcase
      len = $urandom_range(1, 36);
      jv  = 4'($urandom);
      for (int c = 0; c < len; c++)
        tick(($urandom_range(0, 99) == 0), p, (c == 0) ? jv : 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
